mat_vec_mul_acc: RTL
====================

# mat_vec_mul_acc

Parametrised GF(2^8) matrix–vector multiplier with optional accumulate mode: computes res = M·v (overwrite) or res = res ⊕ M·v (accumulate) over GF(2^8), N_GF byte lanes per cycle. It is the next-generation matrix–vector engine for the SDitH datapath. Matrix and vector are streamed from external single-port memories with 1-cycle read latency. The result is held in an internal register file, readable by word address after o_done.

## Interface
- MAT_ROW_SIZE_BYTES, 8: number of matrix rows (= result length in bytes); multiple of N_GF.
- MAT_COL_SIZE_BYTES, 8: number of matrix columns (= vector length in bytes); multiple of N_GF.
- N_GF, 4: parallel GF(2^8) multiplier lanes; word width PROC_SIZE = 8·N_GF.
- Derived: WPR = MAT_COL_SIZE_BYTES/N_GF (words per row); NW = MAT_ROW_SIZE_BYTES·WPR (matrix words); RW = MAT_ROW_SIZE_BYTES/N_GF (result words).
- i_clk  in  1  clock; all logic on rising edge.
- i_rst  in  1  reset, synchronous, active-high.
- i_start  in  1  start request, sampled only in IDLE.
- i_acc  in  1  mode, sampled with i_start: 0 = overwrite, 1 = accumulate.
- o_busy  out  1  high from the cycle after accepted start until o_done.
- o_done  out  1  single-cycle completion pulse.
- o_mat_addr  out  CLOG2(NW)  matrix word address, row-major.
- o_vec_addr  out  CLOG2(WPR)  vector word address.
- i_mat  in  PROC_SIZE  matrix word, valid 1 cycle after address.
- i_vec  in  PROC_SIZE  vector word, valid 1 cycle after address.
- i_res_addr  in  CLOG2(RW)  result word read address.
- o_res  out  PROC_SIZE  registered result word.

## Operation
- Byte packing: byte j of a word is bits [8j+7:8j]; matrix word k holds row k/WPR, columns (k mod WPR)·N_GF+j; vector word w holds elements w·N_GF+j; result word a holds rows a·N_GF+j.
- Field: GF(2^8), reduction polynomial x^8+x^4+x^3+x+1 (0x11B); addition = XOR.
- FSM: IDLE → RUN (on i_start) → FLUSH → DONE → IDLE.
- RUN lasts exactly NW cycles; in RUN cycle k (k = 0..NW-1): o_mat_addr = k, o_vec_addr = k mod WPR.
- Stage 1 (data cycle): N_GF lane products i_mat[j]·i_vec[j], XOR-reduced to one byte, registered.
- Stage 2: row accumulator ⊕= reduced byte; on first word of a row the accumulator is seeded with 0 (i_acc=0) or current result byte of that row (i_acc=1); on last word of a row the final byte is written to the result file.
- FLUSH: 2 cycles draining stages; DONE: o_done=1 for one cycle, then IDLE.
- i_start ignored while not in IDLE; i_acc latched at accepted start and held for the whole run.
- o_res: registered read of result word i_res_addr, every cycle; contents valid only when o_busy=0.
- Result file persists between runs (needed for accumulate).

## Timing
- Start edge E0 samples i_start=1 in IDLE; RUN cycle k spans edges E0+k..E0+k+1.
- o_busy high from E0 until the edge ending the o_done cycle.
- Last result byte written at edge E0+NW+2; o_done high in cycle E0+NW+2..E0+NW+3; total latency NW+2 edges.
- Back-to-back: i_start held high through DONE is accepted in the next IDLE cycle (one idle cycle minimum between runs).
- o_res read latency 1 cycle after i_res_addr.
- Reset (any state, including mid-RUN): next cycle state=IDLE, o_busy=0, o_done=0, o_mat_addr=0, o_vec_addr=0, o_res=0, pipeline registers and entire result file cleared to 0; aborted run produces no o_done.
- In IDLE, o_mat_addr and o_vec_addr hold 0.

## Test plan
- Identity: 8×8 identity, v = 01..08, N_GF=4, i_acc=0 → res words 0x04030201, 0x08070605; o_done exactly NW+2=18 edges after start.
- Field product: M row0 col0 = 0x57, all else 0; v[0]=0x83 → res byte0 = 0xC1, all other bytes 0x00.
- Accumulate: identity run with i_acc=0 then i_acc=1, same v → all result bytes 0x00; third run with i_acc=1 → res = v again.
- Start while busy: pulse i_start at RUN cycle 5 → ignored, single o_done at original time, result unchanged vs. clean run.
- Reset mid-run: assert i_rst at RUN cycle 7 → no o_done, o_busy=0 next cycle, all o_res reads 0x00000000; subsequent clean start yields correct result.
- Parameter sweep: (rows,cols,N_GF) = (16,8,8), (8,16,2) with random M, v vs. software GF(2^8) model → exact match, latency NW+2.

Source files
------------

// File: rtl/mat_vec_mul_acc_if.sv
// Bus bundle for mat_vec_mul_acc: start/done handshake, matrix/vector memory
// read ports and the result-file read port.
interface mat_vec_mul_acc_if #(
  parameter int MAT_ROW_SIZE_BYTES = 8,
  parameter int MAT_COL_SIZE_BYTES = 8,
  parameter int N_GF               = 4
);
  localparam int PROC_SIZE = 8 * N_GF;
  localparam int WPR       = MAT_COL_SIZE_BYTES / N_GF;
  localparam int NW        = MAT_ROW_SIZE_BYTES * WPR;
  localparam int RW        = MAT_ROW_SIZE_BYTES / N_GF;
  localparam int MAW       = (NW > 1) ? $clog2(NW) : 1;
  localparam int VAW       = (WPR > 1) ? $clog2(WPR) : 1;
  localparam int RAW       = (RW > 1) ? $clog2(RW) : 1;

  logic                 i_start;
  logic                 i_acc;
  logic                 o_busy;
  logic                 o_done;
  logic [MAW-1:0]       o_mat_addr;
  logic [VAW-1:0]       o_vec_addr;
  logic [PROC_SIZE-1:0] i_mat;
  logic [PROC_SIZE-1:0] i_vec;
  logic [RAW-1:0]       i_res_addr;
  logic [PROC_SIZE-1:0] o_res;

  modport slave (
    input  i_start, i_acc, i_mat, i_vec, i_res_addr,
    output o_busy, o_done, o_mat_addr, o_vec_addr, o_res
  );

  modport master (
    output i_start, i_acc, i_mat, i_vec, i_res_addr,
    input  o_busy, o_done, o_mat_addr, o_vec_addr, o_res
  );
endinterface

// File: rtl/mat_vec_mul_acc.sv
// GF(2^8) matrix-vector multiplier, res = M*v or res ^= M*v, N_GF lanes per
// cycle; two pipeline stages behind a 1-cycle-latency memory read.
module mat_vec_mul_acc #(
  parameter int MAT_ROW_SIZE_BYTES = 8,
  parameter int MAT_COL_SIZE_BYTES = 8,
  parameter int N_GF               = 4
) (
  input logic              i_clk,
  input logic              i_rst,
  mat_vec_mul_acc_if.slave bus
);
  localparam int PROC_SIZE = 8 * N_GF;
  localparam int ROWS      = MAT_ROW_SIZE_BYTES;
  localparam int WPR       = MAT_COL_SIZE_BYTES / N_GF;
  localparam int NW        = ROWS * WPR;
  localparam int RW        = ROWS / N_GF;
  localparam int MAW       = (NW > 1) ? $clog2(NW) : 1;
  localparam int VAW       = (WPR > 1) ? $clog2(WPR) : 1;
  localparam int RAW       = (RW > 1) ? $clog2(RW) : 1;
  localparam int RBW       = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [MAW-1:0] MAT_LAST = MAW'(NW - 1);
  localparam logic [VAW-1:0] VEC_LAST = VAW'(WPR - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic           valid;
    logic           first;
    logic           last;
    logic [RBW-1:0] row;
  } tag_t;

  state_t               state_q, state_d;
  logic                 busy_q, busy_d, done_q, done_d;
  logic                 acc_mode_q, acc_mode_d, flush_q, flush_d;
  logic [MAW-1:0]       mat_addr_q, mat_addr_d;
  logic [VAW-1:0]       vec_addr_q, vec_addr_d;
  logic [RBW-1:0]       row_q, row_d;
  tag_t                 tag1_q, tag1_d, tag2_q, tag2_d;
  logic [7:0]           prod_q, prod_d, racc_q, racc_d;
  logic [7:0]           res_mem_q [ROWS];
  logic [PROC_SIZE-1:0] res_q, res_d;
  logic [7:0]           seed;
  logic [7:0]           res_wdata;
  logic                 res_we;
  int                   rd_idx;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1B) : {x[6:0], 1'b0};
    end
    return p;
  endfunction

  function automatic logic [7:0] lane_dot(input logic [PROC_SIZE-1:0] m,
                                          input logic [PROC_SIZE-1:0] v);
    logic [7:0] r;
    r = 8'h00;
    for (int j = 0; j < N_GF; j++) r = r ^ gf_mul(m[8*j +: 8], v[8*j +: 8]);
    return r;
  endfunction

  always_comb begin
    state_d    = state_q;
    mat_addr_d = mat_addr_q;
    vec_addr_d = vec_addr_q;
    row_d      = row_q;
    flush_d    = flush_q;
    acc_mode_d = acc_mode_q;
    case (state_q)
      S_IDLE: begin
        if (bus.i_start) begin
          state_d    = S_RUN;
          acc_mode_d = bus.i_acc;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (mat_addr_q == MAT_LAST) begin
          state_d    = S_FLUSH;
          mat_addr_d = '0;
          vec_addr_d = '0;
          row_d      = '0;
          flush_d    = 1'b0;
        end else begin
          mat_addr_d = mat_addr_q + MAW'(1);
          if (vec_addr_q == VEC_LAST) begin
            vec_addr_d = '0;
            row_d      = row_q + RBW'(1);
          end else begin
            vec_addr_d = vec_addr_q + VAW'(1);
          end
        end
      end
      S_FLUSH: begin
        if (flush_q) begin
          state_d = S_DONE;
        end else begin
          flush_d = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // Tags ride alongside the data so stage 2 knows row boundaries without the FSM.
  always_comb begin
    tag1_d       = '0;
    tag1_d.valid = (state_q == S_RUN);
    tag1_d.first = (vec_addr_q == '0);
    tag1_d.last  = (vec_addr_q == VEC_LAST);
    tag1_d.row   = row_q;
    tag2_d       = tag1_q;
    prod_d       = lane_dot(bus.i_mat, bus.i_vec);
    seed         = acc_mode_q ? res_mem_q[tag2_q.row] : 8'h00;
    res_wdata    = (tag2_q.first ? seed : racc_q) ^ prod_q;
    res_we       = tag2_q.valid & tag2_q.last;
    if (tag2_q.valid) begin
      racc_d = res_wdata;
    end else begin
      racc_d = racc_q;
    end
    res_d  = '0;
    rd_idx = 0;
    for (int j = 0; j < N_GF; j++) begin
      rd_idx = int'(bus.i_res_addr) * N_GF + j;
      if (rd_idx < ROWS) begin
        res_d[8*j +: 8] = res_mem_q[rd_idx[RBW-1:0]];
      end else begin
        res_d[8*j +: 8] = 8'h00;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      acc_mode_q <= 1'b0;
      flush_q    <= 1'b0;
      mat_addr_q <= '0;
      vec_addr_q <= '0;
      row_q      <= '0;
      tag1_q     <= '0;
      tag2_q     <= '0;
      prod_q     <= 8'h00;
      racc_q     <= 8'h00;
      res_q      <= '0;
      for (int r = 0; r < ROWS; r++) res_mem_q[r] <= 8'h00;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      acc_mode_q <= acc_mode_d;
      flush_q    <= flush_d;
      mat_addr_q <= mat_addr_d;
      vec_addr_q <= vec_addr_d;
      row_q      <= row_d;
      tag1_q     <= tag1_d;
      tag2_q     <= tag2_d;
      prod_q     <= prod_d;
      racc_q     <= racc_d;
      res_q      <= res_d;
      if (res_we) res_mem_q[tag2_q.row] <= res_wdata;
    end
  end

  assign bus.o_busy     = busy_q;
  assign bus.o_done     = done_q;
  assign bus.o_mat_addr = mat_addr_q;
  assign bus.o_vec_addr = vec_addr_q;
  assign bus.o_res      = res_q;
endmodule
